// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like request/response bus shared by the core masters and the memory port.
//
// Signals:
//   req     request valid, held by the master until addr_ok
//   wr      1 = write, 0 = read
//   size    0/1/2 = byte/half/word
//   wstrb   byte enables for writes
//   addr    byte address
//   wdata   write data
//   addr_ok request accepted this cycle
//   data_ok response this cycle (in issue order)
//   rdata   read data, valid with data_ok
//
// Modports:
//   master  issues requests (drives req..wdata, receives addr_ok/data_ok/rdata)
//   slave   serves requests (receives req..wdata, drives addr_ok/data_ok/rdata)
interface sram_bus_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req,
        output wr,
        output size,
        output wstrb,
        output addr,
        output wdata,
        input  addr_ok,
        input  data_ok,
        input  rdata
    );

    modport slave (
        input  req,
        input  wr,
        input  size,
        input  wstrb,
        input  addr,
        input  wdata,
        output addr_ok,
        output data_ok,
        output rdata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-master arbiter sharing one SRAM-like memory port between the instruction-fetch
// master and the data-access master.
//
// Data has fixed priority over inst, but a request that the memory port has not yet
// accepted keeps its grant (lock) until addr_ok, so a master never sees its request
// change under it. Every accepted request pushes its issuer into an in-order tag FIFO;
// each returning data_ok pops the FIFO and is routed to the recorded issuer.
//
// Ports:
//   clk       clock, all state updates on rising edge
//   reset     asynchronous, active-high reset
//   inst_bus  slave side facing the instruction-fetch master
//   data_bus  slave side facing the data-access master
//   mem_bus   master side facing the shared memory port
//
// Parameters:
//   OUTSTANDING  maximum accepted-but-unanswered transactions (power of two, >= 2)
module sram_bus_arbiter #(
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    sram_bus_arbiter_if.slave         inst_bus,
    sram_bus_arbiter_if.slave         data_bus,
    sram_bus_arbiter_if.master        mem_bus
);

    localparam int unsigned PtrW = $clog2(OUTSTANDING);
    localparam int unsigned CntW = PtrW + 1;

    // Grant lock
    logic lock_valid_q, lock_valid_d;
    logic lock_sel_q, lock_sel_d;

    // Tag FIFO: 1 = data master, 0 = inst master
    logic [OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PtrW-1:0]        wptr_q, wptr_d;
    logic [PtrW-1:0]        rptr_q, rptr_d;
    logic [CntW-1:0]        count_q, count_d;

    logic sel;
    logic full;
    logic accept;
    logic resp;
    logic head_is_data;

    // ------------------------------------------------------------------
    // Grant and request mux
    // ------------------------------------------------------------------
    assign sel  = lock_valid_q ? lock_sel_q : data_bus.req;
    assign full = (count_q == CntW'(OUTSTANDING));

    // Nothing is issued when the tag FIFO is full, even if a response frees a slot
    // in the same cycle; issue resumes once count has dropped.
    assign mem_bus.req   = (sel ? data_bus.req : inst_bus.req) & ~full;
    assign mem_bus.wr    = sel ? data_bus.wr    : inst_bus.wr;
    assign mem_bus.size  = sel ? data_bus.size  : inst_bus.size;
    assign mem_bus.wstrb = sel ? data_bus.wstrb : inst_bus.wstrb;
    assign mem_bus.addr  = sel ? data_bus.addr  : inst_bus.addr;
    assign mem_bus.wdata = sel ? data_bus.wdata : inst_bus.wdata;

    assign accept = mem_bus.req & mem_bus.addr_ok;

    assign data_bus.addr_ok = accept & sel;
    assign inst_bus.addr_ok = accept & ~sel;

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    // A data_ok with nothing outstanding (e.g. left over from before a reset) is
    // dropped: no master sees it and no state moves.
    assign resp         = mem_bus.data_ok & (count_q != '0);
    assign head_is_data = fifo_q[rptr_q];

    assign data_bus.data_ok = resp & head_is_data;
    assign inst_bus.data_ok = resp & ~head_is_data;

    assign inst_bus.rdata = mem_bus.rdata;
    assign data_bus.rdata = mem_bus.rdata;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_sel_d   = lock_sel_q;
        fifo_d       = fifo_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;

        if (accept) begin
            lock_valid_d = 1'b0;
        end else if (mem_bus.req) begin
            // Pending request: pin the grant so a higher-priority arrival cannot
            // swap the address/data presented to the memory port.
            lock_valid_d = 1'b1;
            lock_sel_d   = sel;
        end

        if (accept) begin
            fifo_d[wptr_q] = sel;
            wptr_d         = wptr_q + PtrW'(1);
        end

        if (resp) begin
            rptr_d = rptr_q + PtrW'(1);
        end

        count_d = count_q + CntW'(accept) - CntW'(resp);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_valid_q <= 1'b0;
            lock_sel_q   <= 1'b0;
            fifo_q       <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_sel_q   <= lock_sel_d;
            fifo_q       <= fifo_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: a table of per-cycle vectors plus
// hand-written sequences for the full-FIFO and reset/spurious-response cases.
module tb_sram_bus_arbiter;

    localparam logic [31:0] IADDR  = 32'h0000_0100;
    localparam logic [31:0] DADDR  = 32'h0000_1000;
    localparam logic [31:0] IWDATA = 32'h1357_9BDF;
    localparam logic [31:0] DWDATA = 32'h2468_ACE0;
    localparam logic [1:0]  ISIZE  = 2'd2;
    localparam logic [1:0]  DSIZE  = 2'd1;
    localparam logic [3:0]  IWSTRB = 4'hF;
    localparam logic [3:0]  DWSTRB = 4'h3;

    logic clk;
    logic reset;

    sram_bus_arbiter_if inst_bus ();
    sram_bus_arbiter_if data_bus ();
    sram_bus_arbiter_if mem_bus ();

    sram_bus_arbiter #(
        .OUTSTANDING (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .inst_bus (inst_bus),
        .data_bus (data_bus),
        .mem_bus  (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic        dreq;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        exp_req;
        logic        exp_sel;
        logic        exp_iaok;
        logic        exp_daok;
        logic        exp_idok;
        logic        exp_ddok;
        int          exp_cnt;
    } vec_t;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    function automatic vec_t mk(input logic ireq, input logic dreq, input logic aok,
                                input logic dok, input logic [31:0] rd,
                                input logic ereq, input logic esel,
                                input logic eiaok, input logic edaok,
                                input logic eidok, input logic eddok, input int ecnt);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.aok = aok; v.dok = dok; v.rdata = rd;
        v.exp_req = ereq; v.exp_sel = esel;
        v.exp_iaok = eiaok; v.exp_daok = edaok;
        v.exp_idok = eidok; v.exp_ddok = eddok;
        v.exp_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Called at a falling edge: drive, check combinational outputs, advance one cycle.
    task automatic apply(input string nm, input vec_t v);
        inst_bus.req     = v.ireq;
        data_bus.req     = v.dreq;
        mem_bus.addr_ok  = v.aok;
        mem_bus.data_ok  = v.dok;
        mem_bus.rdata    = v.rdata;
        #2;
        chk(nm, "count", 32'(dut.count_q), 32'(v.exp_cnt));
        chk(nm, "req", 32'(mem_bus.req), 32'(v.exp_req));
        chk(nm, "addr", mem_bus.addr, v.exp_sel ? DADDR : IADDR);
        chk(nm, "size", 32'(mem_bus.size), 32'(v.exp_sel ? DSIZE : ISIZE));
        chk(nm, "wstrb", 32'(mem_bus.wstrb), 32'(v.exp_sel ? DWSTRB : IWSTRB));
        chk(nm, "wdata", mem_bus.wdata, v.exp_sel ? DWDATA : IWDATA);
        chk(nm, "inst_addr_ok", 32'(inst_bus.addr_ok), 32'(v.exp_iaok));
        chk(nm, "data_addr_ok", 32'(data_bus.addr_ok), 32'(v.exp_daok));
        chk(nm, "inst_data_ok", 32'(inst_bus.data_ok), 32'(v.exp_idok));
        chk(nm, "data_data_ok", 32'(data_bus.data_ok), 32'(v.exp_ddok));
        chk(nm, "inst_rdata", inst_bus.rdata, v.rdata);
        chk(nm, "data_rdata", data_bus.rdata, v.rdata);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset           = 1'b1;
        inst_bus.req    = 1'b0;
        inst_bus.wr     = 1'b0;
        inst_bus.size   = ISIZE;
        inst_bus.wstrb  = IWSTRB;
        inst_bus.addr   = IADDR;
        inst_bus.wdata  = IWDATA;
        data_bus.req    = 1'b0;
        data_bus.wr     = 1'b0;
        data_bus.size   = DSIZE;
        data_bus.wstrb  = DWSTRB;
        data_bus.addr   = DADDR;
        data_bus.wdata  = DWDATA;
        mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b0;
        mem_bus.rdata   = 32'h0;

        // Table columns: ireq dreq aok dok rdata | req sel iaok daok idok ddok count
        // Single data read
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'hDEADBEEF,  0, 0, 0, 0, 0, 1, 1));
        // Simultaneous requests: data first, then inst; responses in that order
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 1, 32'h11111111,  0, 0, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 1, 32'h22222222,  0, 0, 0, 0, 1, 0, 1));
        // Lock: inst stalled, data arrives but inst keeps the port
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,         1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,         1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h33333333,  0, 0, 0, 0, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 1, 32'h44444444,  0, 0, 0, 0, 0, 1, 1));
        // Spurious response with nothing outstanding
        vecs.push_back(mk(0, 0, 0, 1, 32'h55555555,  0, 0, 0, 0, 0, 0, 0));
        // Mixed interleave with same-cycle accept+response, pointers wrap
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 32'h66666666,  1, 1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 1, 32'h77777777,  1, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 1, 32'h88888888,  1, 1, 0, 1, 1, 0, 2));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 1, 32'h99999999,  0, 0, 0, 0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0, 1, 32'hAAAAAAAA,  0, 0, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 1, 32'hBBBBBBBB,  0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 32'hCCCCCCCC,  1, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 32'hDDDDDDDD,  1, 1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 1, 32'hEEEEEEEE,  1, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'hFFFFFFFF,  0, 0, 0, 0, 1, 0, 1));

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset", "count", 32'(dut.count_q), 32'd0);
        chk("reset", "wptr", 32'(dut.wptr_q), 32'd0);
        chk("reset", "rptr", 32'(dut.rptr_q), 32'd0);
        chk("reset", "lock_valid", 32'(dut.lock_valid_q), 32'd0);
        chk("reset", "lock_sel", 32'(dut.lock_sel_q), 32'd0);
        chk("reset", "req", 32'(mem_bus.req), 32'd0);
        chk("reset", "oks", {28'd0, inst_bus.addr_ok, data_bus.addr_ok,
                             inst_bus.data_ok, data_bus.data_ok}, 32'd0);
        @(negedge clk);

        foreach (vecs[i]) apply($sformatf("vec[%0d]", i), vecs[i]);

        // Full: three data reads, a stalled inst read that locks, then the fourth
        // accept fills the FIFO; a pending data request must wait until count drops.
        apply("full0", mk(0, 1, 1, 0, 32'h0,        1, 1, 0, 1, 0, 0, 0));
        apply("full1", mk(0, 1, 1, 0, 32'h0,        1, 1, 0, 1, 0, 0, 1));
        apply("full2", mk(0, 1, 1, 0, 32'h0,        1, 1, 0, 1, 0, 0, 2));
        apply("full3", mk(1, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 0, 3));
        apply("full4", mk(1, 1, 1, 0, 32'h0,        1, 0, 1, 0, 0, 0, 3));
        apply("full5", mk(0, 1, 1, 0, 32'h0,        0, 1, 0, 0, 0, 0, 4));
        apply("full6", mk(0, 1, 1, 1, 32'hA5A5A5A5, 0, 1, 0, 0, 0, 1, 4));
        apply("full7", mk(0, 1, 1, 0, 32'h0,        1, 1, 0, 1, 0, 0, 3));
        apply("drain0", mk(0, 0, 0, 1, 32'h01010101, 0, 0, 0, 0, 0, 1, 4));
        apply("drain1", mk(0, 0, 0, 1, 32'h02020202, 0, 0, 0, 0, 0, 1, 3));
        apply("drain2", mk(0, 0, 0, 1, 32'h03030303, 0, 0, 0, 0, 1, 0, 2));
        apply("drain3", mk(0, 0, 0, 1, 32'h04040404, 0, 0, 0, 0, 0, 1, 1));

        // Reset with two requests outstanding, then a stale response
        apply("rst0", mk(0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0, 0));
        apply("rst1", mk(1, 0, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0, 1));
        inst_bus.req    = 1'b0;
        data_bus.req    = 1'b0;
        mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b0;
        #1;
        chk("rst_pre", "count", 32'(dut.count_q), 32'd2);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid", "count", 32'(dut.count_q), 32'd0);
        chk("rst_mid", "wptr", 32'(dut.wptr_q), 32'd0);
        chk("rst_mid", "rptr", 32'(dut.rptr_q), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        apply("stale", mk(0, 0, 0, 1, 32'hBAD0BAD0,  0, 0, 0, 0, 0, 0, 0));
        apply("post0", mk(0, 1, 1, 0, 32'h0,         1, 1, 0, 1, 0, 0, 0));
        apply("post1", mk(0, 0, 0, 1, 32'hC0FFEE00,  0, 0, 0, 0, 0, 1, 1));
        apply("post2", mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Two-master arbiter that shares one SRAM-like bus port between the instruction-fetch side and the data-access side of the pipeline (IF stage and EXE/MEM stages). It grants requests to the shared port and holds a grant until the slave accepts it. It records the issuing master of every accepted transaction in an in-order tag FIFO and routes each returning `data_ok`/`rdata` to the correct master. The block sits between the CPU core and the single external memory interface.

## Interface
Parameters:
- `OUTSTANDING`, 4: maximum accepted-but-unanswered transactions; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `inst_req` / `data_req`  in  1  master request, held until that master's `*_addr_ok`.
- `inst_wr` / `data_wr`  in  1  1 = write, 0 = read.
- `inst_size` / `data_size`  in  2  0/1/2 = byte/half/word.
- `inst_wstrb` / `data_wstrb`  in  4  byte enables for writes.
- `inst_addr` / `data_addr`  in  32  byte address.
- `inst_wdata` / `data_wdata`  in  32  write data.
- `inst_addr_ok` / `data_addr_ok`  out  1  request accepted this cycle.
- `inst_data_ok` / `data_data_ok`  out  1  response for this master this cycle.
- `inst_rdata` / `data_rdata`  out  32  read data, valid with `*_data_ok`.
- `req`, `wr`, `size`, `wstrb`, `addr`, `wdata`  out  1/1/2/4/32/32  shared slave request.
- `addr_ok`  in  1  slave accepted `req`.
- `data_ok`  in  1  slave response, in issue order.
- `rdata`  in  32  slave read data.

## Operation
- State:
  - `lock_valid`, `lock_sel` (0 = inst, 1 = data).
  - Tag FIFO of `OUTSTANDING` 1-bit entries with `wptr` and `rptr` (log2(OUTSTANDING) bits each).
  - `count` (log2(OUTSTANDING)+1 bits).
- Grant:
  - If `lock_valid`, `sel = lock_sel`.
  - Otherwise `sel = data_req` (data has fixed priority over inst).
- `full = (count == OUTSTANDING)`.
- Slave request:
  - `req = (sel ? data_req : inst_req) & !full`.
  - `wr/size/wstrb/addr/wdata` are muxed from the selected master.
- Acceptance:
  - `accept = req & addr_ok`.
  - `data_addr_ok = accept & sel`; `inst_addr_ok = accept & !sel`.
  - On accept: `fifo[wptr] <= sel` and `wptr` increments.
- Lock:
  - When `req & !addr_ok`, set `lock_valid <= 1` and `lock_sel <= sel`.
  - Clear `lock_valid` on accept.
  - While locked, the other master never reaches the slave, even if it has higher priority.
- Response:
  - `resp = data_ok & (count != 0)`.
  - `data_data_ok = resp & fifo[rptr]`; `inst_data_ok = resp & !fifo[rptr]`.
  - `rdata` fans out to both masters unmodified.
  - On `resp`, `rptr` increments.
- Count update:
  - `count <= count + accept - resp`.
  - Accept and resp in the same cycle leaves `count` unchanged and advances both pointers.
- Boundaries:
  - Pointers wrap modulo `OUTSTANDING`.
  - When full, `req` is 0 even if a `data_ok` arrives that cycle. Issue resumes the cycle after `count` drops.
  - A `data_ok` while `count == 0` is spurious. It is dropped, no master sees it, and no state changes.
  - A lock is held even when `full` is reached.
  - Reset mid-operation discards all outstanding tags. Responses that arrive after reset for pre-reset requests are treated as spurious while `count == 0`.

## Timing
- Reset values:
  - `count = 0`, `wptr = rptr = 0`, `lock_valid = 0`, `lock_sel = 0`.
  - All `*_addr_ok`, `*_data_ok` and `req` outputs are 0, since no master is requesting after reset.
- Latency:
  - The request path is combinational: master `req` to slave `req`, and slave `addr_ok` to master `addr_ok`, in the same cycle.
  - The response path is combinational: slave `data_ok`/`rdata` to the selected master in the same cycle.
- The earliest response to a request accepted at cycle N is cycle N+1. A same-cycle `data_ok` sees the pre-accept `count`.
- Throughput is one accept per cycle, limited only by `addr_ok` and `full`.
- Registered state (lock, FIFO, pointers, count) updates at the rising edge after the event.

## Test plan
- Single data read:
  - Stimulus: `data_req=1`, `addr=0x0000_1000`, `wr=0`, `addr_ok=1` at cycle 0; slave `data_ok=1` with `rdata=0xDEADBEEF` at cycle 2.
  - Required: `data_addr_ok=1` at cycle 0; `data_data_ok=1` and `data_rdata=0xDEADBEEF` at cycle 2; `inst_data_ok=0` throughout.
- Simultaneous requests:
  - Stimulus: `inst_req=data_req=1` at cycle 0, `addr_ok=1`; responses at cycles 3 and 4.
  - Required: data is accepted at cycle 0 and inst at cycle 1; cycle 3 response goes to data only, cycle 4 response to inst only.
- Lock:
  - Stimulus: `inst_req` alone at cycle 0 with `addr_ok=0` for cycles 0–1; `data_req` rises at cycle 1; `addr_ok=1` from cycle 2.
  - Required: slave `addr` equals `inst_addr` for cycles 0–2; `inst_addr_ok` at cycle 2; `data_addr_ok` at cycle 3.
- Full:
  - Stimulus: 4 accepted reads with no response, then a 5th request.
  - Required: `req=0` and `count=4`; after one `data_ok`, `count=3` and the 5th request is accepted the following cycle.
- Mixed wrap:
  - Stimulus: 10 interleaved inst/data accepts and responses with `count` ≤ 4.
  - Required: every response is routed to its issuer in order; pointers wrap correctly.
- Reset mid-op and spurious response:
  - Stimulus: 2 requests outstanding, assert `reset` mid-cycle; then a `data_ok` arrives.
  - Required: `count=0` immediately after `reset`; the later `data_ok` drives neither `inst_data_ok` nor `data_data_ok`.
